// File: rtl/spi_reg_pkg.sv
// Shared types for the SPI register master.
// Default frame geometry, FSM states and the frame word type.
package spi_reg_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      HOLD,
      GAP
   } state_t;

   typedef logic [AW_DEF+DW_DEF-1:0] frame_t;

endpackage

// File: rtl/spi_reg_master_arb_arbiter.sv
// Round-robin arbiter: one-hot grant plus index.
// The pointer moves to the winner whenever a grant is taken.
module spi_rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] sel;

   // Walk from the farthest slot down so the nearest one after ptr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      sel   = '0;
      for (int off = NREQ; off >= 1; off--) begin
         sel = IDW'((int'(ptr) + off) % NREQ);
         if (req[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            idx        = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= IDW'(NREQ - 1);
      else if (en && |req)
         ptr <= idx;
   end

endmodule

// File: rtl/spi_reg_master_arb.sv
// SPI mode-0 register master shared by NREQ requesters.
// Frames are {addr, wdata}; the last DW MISO bits return as read data.
module spi_reg_master_arb
   import spi_reg_pkg::*;
#(
   parameter  int AW      = AW_DEF,
   parameter  int DW      = DW_DEF,
   parameter  int NREQ    = 2,
   parameter  int CLK_DIV = 4,
   parameter  int CS_GAP  = 2,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [DW-1:0]      rsp_rdata,
   output logic               busy,
   output logic               spi_cs,
   output logic               spi_clk,
   output logic               spi_mosi,
   input  logic               spi_miso
);

   localparam int FW  = AW + DW;
   localparam int BCW = $clog2(FW + 1);
   localparam int DCW = $clog2(CLK_DIV * CS_GAP + 1);

   state_t          state, state_nx;
   logic [DCW-1:0]  div;
   logic [BCW-1:0]  bits;
   logic [FW-1:0]   tx;
   logic [DW-1:0]   rx;
   logic [IDW-1:0]  id_q;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic            arb_en;
   logic            accept;
   logic            ph_last;
   logic            last_bit;
   logic            frame_end;

   assign arb_en    = (state == IDLE);
   assign accept    = arb_en && |req_valid;
   assign last_bit  = (bits == BCW'(FW - 1));
   assign frame_end = (state == GAP) && (div == '0);

   spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .en    (arb_en),
      .grant (grant),
      .idx   (gidx)
   );

   always_comb begin
      ph_last  = (div == DCW'(CLK_DIV - 1));
      state_nx = state;
      if (state == GAP)
         ph_last = (div == DCW'(CLK_DIV * CS_GAP - 1));
      unique case (state)
         IDLE:     if (|req_valid) state_nx = SETUP;
         SETUP:    if (ph_last) state_nx = SHIFT_LO;
         SHIFT_LO: if (ph_last) state_nx = SHIFT_HI;
         SHIFT_HI: if (ph_last) state_nx = last_bit ? HOLD : SHIFT_LO;
         HOLD:     if (ph_last) state_nx = GAP;
         GAP:      if (ph_last) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         div   <= '0;
         bits  <= '0;
         tx    <= '0;
         rx    <= '0;
         id_q  <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state || state == IDLE)
            div <= '0;
         else
            div <= div + 1'b1;
         if (accept) begin
            tx   <= {req_addr[gidx*AW +: AW], req_wdata[gidx*DW +: DW]};
            id_q <= gidx;
            bits <= '0;
         end
         if (state == SHIFT_HI && ph_last) begin
            tx   <= {tx[FW-2:0], 1'b0};
            rx   <= {rx[DW-2:0], spi_miso};
            bits <= bits + 1'b1;
         end
      end
   end

   // Pins follow the state one cycle late, so MOSI and SCLK-fall share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
         spi_cs    <= 1'b1;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
      end else begin
         req_ready <= accept ? grant : '0;
         busy      <= (state_nx != IDLE);
         spi_cs    <= !(state inside {SETUP, SHIFT_LO, SHIFT_HI, HOLD});
         spi_clk   <= (state == SHIFT_HI);
         spi_mosi  <= (state inside {SETUP, SHIFT_LO, SHIFT_HI}) ? tx[FW-1] : 1'b0;
         rsp_valid <= frame_end;
         if (frame_end) begin
            rsp_id    <= id_q;
            rsp_rdata <= rx;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_master_arb.sv
// Scoreboarded bench: two masters (default divider and CLK_DIV=1)
// against a mode-0 register-file slave model.
module tb_spi_reg_master_arb;
   import spi_reg_pkg::*;

   typedef struct {
      int          id;
      logic [15:0] rdata;
      frame_t      word;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid [2];
   logic [15:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [1:0]  req_ready [2];
   logic        rsp_valid [2];
   logic        rsp_id    [2];
   logic [15:0] rsp_rdata [2];
   logic        busy      [2];
   logic        cs        [2];
   logic        sck       [2];
   logic        mosi      [2];
   logic        miso      [2] = '{1'b0, 1'b0};

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t acc_q [2][$];
   exp_t pend  [2][$];

   logic        prev_cs   [2] = '{1'b1, 1'b1};
   logic        prev_sck  [2] = '{1'b0, 1'b0};
   logic        prev_mosi [2] = '{1'b0, 1'b0};
   logic        prev_busy [2] = '{1'b0, 1'b0};
   logic        unstable  [2] = '{1'b0, 1'b0};
   logic        seen      [2] = '{1'b0, 1'b0};
   int          s_cnt     [2] = '{0, 0};
   int          lo_cnt    [2] = '{0, 0};
   int          hi_cnt    [2] = '{0, 0};
   int          last_lo   [2] = '{0, 0};
   int          t_acc     [2] = '{0, 0};
   logic [23:0] s_word    [2] = '{24'h0, 24'h0};
   logic [15:0] s_dsh     [2] = '{16'h0, 16'h0};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_reg_master_arb #(
      .AW(8), .DW(16), .NREQ(2), .CLK_DIV(4), .CS_GAP(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
      .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
      .spi_cs(cs[0]), .spi_clk(sck[0]),
      .spi_mosi(mosi[0]), .spi_miso(miso[0])
   );

   spi_reg_master_arb #(
      .AW(8), .DW(16), .NREQ(2), .CLK_DIV(1), .CS_GAP(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
      .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
      .spi_cs(cs[1]), .spi_clk(sck[1]),
      .spi_mosi(mosi[1]), .spi_miso(miso[1])
   );

   function automatic logic [15:0] slave_data(input logic [7:0] a);
      return (a == 8'h00) ? 16'h1234 : {a ^ 8'hA5, ~a};
   endfunction

   task automatic chk(input string name, input int g,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h", name, g, got, want);
      end
   endtask

   // Slave model plus scoreboard monitor for one master.
   task automatic mon(input int g);
      exp_t e;
      int   lat;
      int   cslo;
      int   gapmin;
      lat    = (g == 0) ? 201 : 51;
      cslo   = (g == 0) ? 200 : 50;
      gapmin = (g == 0) ? 8 : 1;
      if (!rst_n) begin
         chk("reset_outputs", g,
             {8'h0, cs[g], sck[g], mosi[g], busy[g], rsp_valid[g],
              rsp_id[g], req_ready[g], rsp_rdata[g]},
             32'h0080_0000);
         pend[g].delete();
         lo_cnt[g] = 0;
         seen[g]   = 1'b0;
      end else begin
         if (cs[g] && !prev_cs[g]) begin
            last_lo[g] = lo_cnt[g];
            hi_cnt[g]  = 0;
         end
         if (!cs[g] && prev_cs[g]) begin
            if (seen[g])
               chk("cs_gap_min", g, 32'(hi_cnt[g] >= gapmin), 1);
            lo_cnt[g]   = 0;
            s_cnt[g]    = 0;
            s_word[g]   = '0;
            unstable[g] = 1'b0;
            miso[g]     = 1'b0;
         end
         if (cs[g]) hi_cnt[g]++;
         else lo_cnt[g]++;
         if (!cs[g] && sck[g] && !prev_sck[g]) begin
            s_word[g] = {s_word[g][22:0], mosi[g]};
            s_cnt[g]++;
            if (s_cnt[g] == 8) s_dsh[g] = slave_data(s_word[g][7:0]);
         end
         if (!cs[g] && !sck[g] && prev_sck[g] && s_cnt[g] >= 8) begin
            miso[g]  = s_dsh[g][15];
            s_dsh[g] = {s_dsh[g][14:0], 1'b0};
         end
         if (sck[g] && mosi[g] !== prev_mosi[g]) unstable[g] = 1'b1;
         if (|req_ready[g]) begin
            if (acc_q[g].size() == 0) begin
               chk("unexpected_grant", g, 32'(req_ready[g]), 0);
            end else begin
               e = acc_q[g].pop_front();
               chk("grant", g, 32'(req_ready[g]), 32'(1) << e.id);
               chk("busy_on_accept", g, 32'(busy[g]), 1);
               pend[g].push_back(e);
               t_acc[g] = cyc;
            end
         end
         if (rsp_valid[g]) begin
            if (pend[g].size() == 0) begin
               chk("unexpected_rsp", g, 1, 0);
            end else begin
               e = pend[g].pop_front();
               chk("rsp_id", g, 32'(rsp_id[g]), e.id);
               chk("rsp_rdata", g, 32'(rsp_rdata[g]), 32'(e.rdata));
               chk("mosi_word", g, 32'(s_word[g]), 32'(e.word));
               chk("sclk_edges", g, s_cnt[g], 24);
               chk("latency", g, cyc - t_acc[g], lat);
               chk("cs_low_len", g, last_lo[g], cslo);
               chk("mosi_stable", g, 32'(unstable[g]), 0);
               chk("cs_with_rsp", g, 32'(cs[g]), 1);
               seen[g] = 1'b1;
            end
         end
         if (prev_busy[g] && !busy[g])
            chk("busy_fall_idle", g,
                {30'h0, cs[g], pend[g].size() == 0}, 32'h3);
      end
      prev_cs[g]   = cs[g];
      prev_sck[g]  = sck[g];
      prev_mosi[g] = mosi[g];
      prev_busy[g] = busy[g];
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) mon(g);
   end

   task automatic expect_frame(input int g, input int id, input logic [7:0] a,
                               input logic [15:0] d, input logic [15:0] rd);
      exp_t e;
      e.id    = id;
      e.rdata = rd;
      e.word  = {a, d};
      acc_q[g].push_back(e);
   endtask

   task automatic wait_acc(input int g);
      int t;
      t = 0;
      while (acc_q[g].size() != 0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (acc_q[g].size() != 0) begin
         chk("accept_timeout", g, acc_q[g].size(), 0);
         acc_q[g].delete();
      end
   endtask

   task automatic wait_idle(input int g);
      int t;
      t = 0;
      while ((pend[g].size() != 0 || busy[g]) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (pend[g].size() != 0 || busy[g]) begin
         chk("idle_timeout", g, pend[g].size(), 0);
         pend[g].delete();
      end
   endtask

   task automatic issue(input int g, input int id, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] rd);
      expect_frame(g, id, a, d, rd);
      @(posedge clk); #1;
      req_addr[g][id*8 +: 8]   = a;
      req_wdata[g][id*16 +: 16] = d;
      req_valid[g][id]          = 1'b1;
      wait_acc(g);
      req_valid[g][id] = 1'b0;
   endtask

   initial begin
      int t;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = '0;
         req_addr[g]  = '0;
         req_wdata[g] = '0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      issue(0, 0, 8'h00, 16'h0000, 16'h1234);
      wait_idle(0);
      issue(0, 1, 8'h10, 16'h00AA, 16'hB5EF);
      wait_idle(0);

      expect_frame(0, 0, 8'h21, 16'h1111, 16'h84DE);
      expect_frame(0, 1, 8'h42, 16'h2222, 16'hE7BD);
      expect_frame(0, 0, 8'h21, 16'h1111, 16'h84DE);
      expect_frame(0, 1, 8'h42, 16'h2222, 16'hE7BD);
      @(posedge clk); #1;
      req_addr[0]  = {8'h42, 8'h21};
      req_wdata[0] = {16'h2222, 16'h1111};
      req_valid[0] = 2'b11;
      wait_acc(0);
      req_valid[0] = 2'b00;
      wait_idle(0);

      issue(0, 0, 8'h6C, 16'hFFFF, 16'h0000);
      t = 0;
      while (s_cnt[0] < 10 && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      if (s_cnt[0] < 10) chk("bit10_timeout", 0, s_cnt[0], 10);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      expect_frame(0, 0, 8'h33, 16'h0102, 16'h96CC);
      expect_frame(0, 1, 8'h05, 16'h0304, 16'hA0FA);
      req_addr[0]  = {8'h05, 8'h33};
      req_wdata[0] = {16'h0304, 16'h0102};
      req_valid[0] = 2'b11;
      wait_acc(0);
      req_valid[0] = 2'b00;
      wait_idle(0);

      issue(0, 0, 8'h01, 16'h0F0F, 16'hA4FE);
      repeat (5) @(posedge clk);
      #1;
      req_addr[0][15:8] = 8'h55;
      req_valid[0][1]   = 1'b1;
      repeat (3) @(posedge clk);
      #1 req_valid[0][1] = 1'b0;
      wait_idle(0);
      repeat (20) @(posedge clk);

      issue(1, 1, 8'h7F, 16'hC3C3, 16'hDA80);
      wait_idle(1);
      repeat (10) @(posedge clk);
      #1;
      chk("queues_empty", 0,
          acc_q[0].size() + acc_q[1].size() + pend[0].size() + pend[1].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
